// File: rtl/fs_bist_pkg.sv
// Shared constants and FSM state type for the full-subtractor BIST checker.
package fs_bist_pkg;
    localparam int unsigned VEC_W   = 3;
    localparam int unsigned NUM_VEC = 8;
    localparam int unsigned ERR_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/fs_golden.sv
// Combinational golden full subtractor: {borr,diff} = a - b - c.
module fs_golden (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic diff_o,
    output logic borr_o
);
    assign diff_o = a_i ^ b_i ^ c_i;
    assign borr_o = (~a_i & b_i) | (~a_i & c_i) | (b_i & c_i);
endmodule

// File: rtl/fs_bist_checker.sv
// BIST controller: walks all {A,B,C} vectors into a full subtractor, holds each
// HOLD_CYCLES cycles, samples at the end of the hold and scores against fs_golden.
module fs_bist_checker
    import fs_bist_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    input  logic             diff_i,
    input  logic             borr_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [VEC_W-1:0] first_fail_vec
);
    localparam int unsigned        HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [VEC_W-1:0]   VEC_LAST  = VEC_W'(NUM_VEC - 1);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               fvalid_q, fvalid_d;
    logic [VEC_W-1:0]   ffvec_q, ffvec_d;

    logic gold_diff, gold_borr;
    logic mismatch;

    fs_golden u_golden (
        .a_i    (vec_q[2]),
        .b_i    (vec_q[1]),
        .c_i    (vec_q[0]),
        .diff_o (gold_diff),
        .borr_o (gold_borr)
    );

    assign mismatch = ({diff_i, borr_i} != {gold_diff, gold_borr});

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        hold_d   = hold_q;
        err_d    = err_q;
        fvalid_d = fvalid_q;
        ffvec_d  = ffvec_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    vec_d    = '0;
                    hold_d   = '0;
                    err_d    = '0;
                    fvalid_d = 1'b0;
                    ffvec_d  = '0;
                end
            end
            RUN: begin
                if (hold_q == HOLD_LAST) begin
                    if (mismatch) begin
                        err_d = err_q + ERR_W'(1);
                        if (!fvalid_q) begin
                            fvalid_d = 1'b1;
                            ffvec_d  = vec_q;
                        end
                    end
                    hold_d = '0;
                    // vec doubles as the DUT drive register, so it parks at 0 in DONE.
                    if (vec_q == VEC_LAST) begin
                        state_d = DONE;
                        vec_d   = '0;
                    end else begin
                        vec_d = vec_q + VEC_W'(1);
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            hold_q   <= '0;
            err_q    <= '0;
            fvalid_q <= 1'b0;
            ffvec_q  <= '0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
            fvalid_q <= fvalid_d;
            ffvec_q  <= ffvec_d;
        end
    end

    assign a_o            = vec_q[2];
    assign b_o            = vec_q[1];
    assign c_o            = vec_q[0];
    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign pass           = done && (err_q == '0);
    assign err_count      = err_q;
    assign fail_valid     = fvalid_q;
    assign first_fail_vec = ffvec_q;
endmodule
